tinker_fetch_unit: RTL and testbench

- Instruction-fetch front end for the tinker pipeline. It sits directly upstream of the IF/ID latch.
- Owns the fetch PC and issues 32-bit instruction reads to a variable-latency instruction port with in-order responses.
- Buffers returned instructions in a prefetch FIFO and hands {instr, pc, pc+4} to decode over a valid/ready handshake.
- Handles taken-branch redirects from EX by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/tinker_fetch_unit.sv | 125 ++++++++++++
 tb/tb_tinker_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_fetch_unit.sv
`default_nettype none
// ============================================================================
// tinker_fetch_unit : fetch PC, credit-limited imem issue, prefetch FIFO, redirect flush
// Revision 1.0
// ============================================================================
module tinker_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h2000,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic [63:0] out_pc4,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        busy
);

  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_OUT_W = $clog2(MAX_OUT + 1) + 1;
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_SUM_W = c_CNT_W + c_OUT_W + 1;

  logic [63:0]        r_fetch_pc;
  logic [63:0]        r_resp_pc;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_OUT_W-1:0] r_outstanding;
  logic [c_OUT_W-1:0] r_drop_cnt;
  logic               r_halted;
  logic [31:0]        r_fifo_instr [DEPTH];
  logic [63:0]        r_fifo_pc    [DEPTH];

  logic [c_SUM_W-1:0] w_credit_sum;
  logic               w_req;
  logic               w_issue;
  logic               w_drop_rsp;
  logic               w_acc_rsp;
  logic               w_out_valid;
  logic               w_pop;
  logic               w_rv_consumes;
  logic [c_OUT_W-1:0] w_drop_redirect;
  logic [63:0]        w_target;
  logic               w_unused;

  // Dropped responses still occupy a slot in memory, so they count against credit.
  assign w_credit_sum = c_SUM_W'(r_count) + c_SUM_W'(r_outstanding) + c_SUM_W'(r_drop_cnt);
  assign w_req        = !reset && !r_halted && !redirect &&
                        (r_outstanding < c_OUT_W'(MAX_OUT)) &&
                        (w_credit_sum < c_SUM_W'(DEPTH));
  assign w_issue      = w_req && imem_gnt;

  assign w_drop_rsp   = imem_rvalid && (r_drop_cnt != '0);
  assign w_acc_rsp    = imem_rvalid && (r_drop_cnt == '0) && (r_outstanding != '0) && !redirect;

  assign w_out_valid  = !reset && (r_count != '0) && !redirect;
  assign w_pop        = w_out_valid && out_ready;

  assign w_rv_consumes   = imem_rvalid && ((r_drop_cnt != '0) || (r_outstanding != '0));
  assign w_drop_redirect = r_drop_cnt + r_outstanding - c_OUT_W'(w_rv_consumes);
  assign w_target        = {redirect_pc[63:2], 2'b00};
  assign w_unused        = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_halted      <= 1'b0;
    end else begin
      if (redirect) begin
        r_fetch_pc    <= w_target;
        r_resp_pc     <= w_target;
        r_count       <= '0;
        r_head        <= '0;
        r_tail        <= '0;
        r_outstanding <= '0;
        r_drop_cnt    <= w_drop_redirect;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 64'd4;
        if (w_acc_rsp) begin
          r_resp_pc <= r_resp_pc + 64'd4;
          r_tail    <= r_tail + c_PTR_W'(1);
        end
        if (w_pop) r_head <= r_head + c_PTR_W'(1);
        r_count       <= r_count + c_CNT_W'(w_acc_rsp) - c_CNT_W'(w_pop);
        r_outstanding <= r_outstanding + c_OUT_W'(w_issue) - c_OUT_W'(w_acc_rsp);
        r_drop_cnt    <= r_drop_cnt - c_OUT_W'(w_drop_rsp);
      end
      if (halt) r_halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_acc_rsp) begin
      r_fifo_instr[r_tail] <= imem_rdata;
      r_fifo_pc[r_tail]    <= r_resp_pc;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign out_valid = w_out_valid;
  assign out_instr = r_fifo_instr[r_head];
  assign out_pc    = r_fifo_pc[r_head];
  assign out_pc4   = r_fifo_pc[r_head] + 64'd4;
  assign busy      = !reset && ((r_outstanding != '0) || (r_drop_cnt != '0));

endmodule
`default_nettype wire

// File: tb/tb_tinker_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_tinker_fetch_unit : directed scenarios against a queue-based fetch model
// Revision 1.0
// ============================================================================
module tb_tinker_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h2000;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_pc4;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        halt = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  tinker_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc4(out_pc4),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // Memory: in-order responses, fixed latency lat cycles after issue.
  int          lat = 1;
  int          cyc = 0;
  logic [63:0] mq_addr[$];
  int          mq_due[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Model: in-flight requests tagged stale on redirect; the FIFO holds delivered PCs.
  logic [63:0] m_fetch = RESET_PC;
  bit          m_halted = 1'b0;
  logic [63:0] m_fifo[$];
  logic [63:0] m_fl_addr[$];
  bit          m_fl_stale[$];
  int          live;
  bit          e_req, e_ov, s;
  logic [63:0] a;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_req", imem_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      m_fetch = RESET_PC; m_halted = 1'b0;
      m_fifo.delete(); m_fl_addr.delete(); m_fl_stale.delete();
      mq_addr.delete(); mq_due.delete();
    end else begin
      live = 0;
      foreach (m_fl_stale[i]) if (!m_fl_stale[i]) live++;
      e_req = !m_halted && !redirect && (live < MAX_OUT) &&
              ((m_fifo.size() + m_fl_addr.size()) < DEPTH);
      e_ov  = (m_fifo.size() != 0) && !redirect;
      chk("imem_req", imem_req, e_req);
      chk("imem_addr", imem_addr, m_fetch);
      chk("out_valid", out_valid, e_ov);
      if (e_ov) begin
        chk("out_pc", out_pc, m_fifo[0]);
        chk("out_pc4", out_pc4, m_fifo[0] + 64'd4);
        chk("out_instr", out_instr, instr_of(m_fifo[0]));
      end
      chk("busy", busy, m_fl_addr.size() != 0);

      if (imem_rvalid && mq_addr.size() != 0) begin
        void'(mq_addr.pop_front()); void'(mq_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        mq_addr.push_back(imem_addr); mq_due.push_back(cyc + lat);
      end

      if (redirect) begin
        if (imem_rvalid && m_fl_addr.size() != 0) begin
          void'(m_fl_addr.pop_front()); void'(m_fl_stale.pop_front());
        end
        foreach (m_fl_stale[i]) m_fl_stale[i] = 1'b1;
        m_fifo.delete();
        m_fetch = redirect_pc & ~64'h3;
      end else begin
        if (e_ov && out_ready) void'(m_fifo.pop_front());
        if (imem_rvalid && m_fl_addr.size() != 0) begin
          a = m_fl_addr.pop_front();
          s = m_fl_stale.pop_front();
          if (!s) m_fifo.push_back(a);
        end
        if (e_req && imem_gnt) begin
          m_fl_addr.push_back(m_fetch); m_fl_stale.push_back(1'b0);
          m_fetch = m_fetch + 64'd4;
        end
      end
      if (halt) m_halted = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Leaves the bench at the start of the first cycle after reset.
  task automatic do_reset(input int l);
    reset = 1'b1; redirect = 1'b0; halt = 1'b0; lat = l;
    step();
    @(negedge clk);
    chk("lit_rst_req", imem_req, 0);
    chk("lit_rst_busy", busy, 0);
    step();
    reset = 1'b0;
  endtask

  task automatic s1_checks(input string tag);
    @(negedge clk);
    chk({tag, "_c0_req"}, imem_req, 1);
    chk({tag, "_c0_addr"}, imem_addr, 64'h2000);
    chk({tag, "_c0_ov"}, out_valid, 0);
    step(); @(negedge clk);
    chk({tag, "_c1_addr"}, imem_addr, 64'h2004);
    chk({tag, "_c1_busy"}, busy, 1);
    chk({tag, "_c1_ov"}, out_valid, 0);
    step(); @(negedge clk);
    chk({tag, "_c2_ov"}, out_valid, 1);
    chk({tag, "_c2_pc"}, out_pc, 64'h2000);
    chk({tag, "_c2_pc4"}, out_pc4, 64'h2004);
    chk({tag, "_c2_addr"}, imem_addr, 64'h2008);
    step(); @(negedge clk);
    chk({tag, "_c3_pc"}, out_pc, 64'h2004);
    chk({tag, "_c3_addr"}, imem_addr, 64'h200C);
    step(); @(negedge clk);
    chk({tag, "_c4_pc"}, out_pc, 64'h2008);
    chk({tag, "_c4_instr"}, out_instr, 64'hC0DE2008);
  endtask

  initial begin
    // Streaming with a 1-cycle memory
    out_ready = 1'b1; imem_gnt = 1'b1;
    do_reset(1);
    s1_checks("s1");
    repeat (4) step();

    // Decode stalled: FIFO fills with exactly four instructions
    out_ready = 1'b0;
    do_reset(1);
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s2_full_req", imem_req, 0);
      chk("s2_head", out_pc, 64'h2000);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk); chk("s2_c7_req", imem_req, 0); chk("s2_c7_pc", out_pc, 64'h2000);
    step(); @(negedge clk);
    chk("s2_c8_req", imem_req, 1); chk("s2_c8_addr", imem_addr, 64'h2010);
    chk("s2_c8_pc", out_pc, 64'h2004);
    step(); @(negedge clk); chk("s2_c9_pc", out_pc, 64'h2008);
    step(); @(negedge clk); chk("s2_c10_pc", out_pc, 64'h200C);
    repeat (3) step();

    // Redirect with two stale requests at a 3-cycle memory
    out_ready = 1'b1;
    do_reset(3);
    repeat (2) step();
    redirect = 1'b1; redirect_pc = 64'h3000;
    @(negedge clk);
    chk("s3_rd_req", imem_req, 0); chk("s3_rd_ov", out_valid, 0); chk("s3_rd_busy", busy, 1);
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("s3_c3_addr", imem_addr, 64'h3000); chk("s3_c3_busy", busy, 1);
    repeat (2) step(); @(negedge clk);
    chk("s3_c5_busy", busy, 1); chk("s3_c5_req", imem_req, 0);
    repeat (2) step(); @(negedge clk);
    chk("s3_c7_ov", out_valid, 1); chk("s3_c7_pc", out_pc, 64'h3000);
    repeat (4) step();

    // Redirect coinciding with rvalid, gnt and out_ready; unaligned target
    out_ready = 1'b1;
    do_reset(1);
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 64'h3003;
    @(negedge clk);
    chk("s4_rd_req", imem_req, 0); chk("s4_rd_ov", out_valid, 0);
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("s4_c4_ov", out_valid, 0); chk("s4_c4_req", imem_req, 1);
    chk("s4_c4_addr", imem_addr, 64'h3000); chk("s4_c4_busy", busy, 0);
    repeat (2) step(); @(negedge clk);
    chk("s4_c6_pc", out_pc, 64'h3000); chk("s4_c6_pc4", out_pc4, 64'h3004);
    repeat (3) step();

    // Halt with two outstanding; halt is sticky after the input drops
    out_ready = 1'b1;
    do_reset(3);
    repeat (2) step();
    halt = 1'b1;
    @(negedge clk); chk("s5_c2_req", imem_req, 0);
    step(); halt = 1'b0;
    @(negedge clk); chk("s5_c3_req", imem_req, 0);
    step(); @(negedge clk);
    chk("s5_c4_req", imem_req, 0); chk("s5_c4_pc", out_pc, 64'h2000);
    step(); @(negedge clk);
    chk("s5_c5_pc", out_pc, 64'h2004); chk("s5_c5_busy", busy, 0); chk("s5_c5_req", imem_req, 0);
    step(); @(negedge clk);
    chk("s5_c6_ov", out_valid, 0);
    step();
    redirect = 1'b1; redirect_pc = 64'h4000;
    @(negedge clk); chk("s5_rd_req", imem_req, 0);
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("s5_c8_req", imem_req, 0); chk("s5_c8_addr", imem_addr, 64'h4000);
    chk("s5_c8_busy", busy, 0);
    repeat (3) step();

    // Reset mid-stream with three FIFO entries, then a clean restart
    out_ready = 1'b0;
    do_reset(1);
    repeat (4) step();
    reset = 1'b1;
    @(negedge clk);
    chk("s6_rst_ov", out_valid, 0); chk("s6_rst_req", imem_req, 0);
    out_ready = 1'b1;
    step(); reset = 1'b0;
    s1_checks("s6");
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
